pulse_bcd_digits: RTL and testbench

- Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders on the pulse generator board.
- Converts an unsigned binary count (pulse count, period or frequency) into DIGITS 4-bit digit codes, one per display digit. The codes are the decoder's native set: 0-9 = numerals, 4'b1110 = 'e', 4'b1111 = blank.
- Uses iterative shift-add-3 (double dabble) over WIDTH cycles, with a start/busy/done handshake.
- Output codes are held stable between conversions so the display never flickers.

---
 rtl/pulse_bcd_digits.sv | 143 ++++++++++++++
 tb/tb_pulse_bcd_digits.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_bcd_digits.sv
// Sequential binary-to-BCD converter (double dabble) feeding the per-digit seven-segment decoders.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (4'hF) in the result.
module pulse_bcd_digits #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [WIDTH-1:0]      VALUE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [4*DIGITS-1:0]   DIGIT_BUS
);

    localparam int NIBS  = DIGITS + 1;
    localparam int BCD_W = 4 * NIBS;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 ovf_cap_q, ovf_cap_d;
    logic [4*DIGITS-1:0]  digit_q, digit_d;

    logic [BCD_W-2:0]     bcd_adj;
    logic [4*DIGITS-1:0]  digits_fmt;

    // Add-3 correction on every nibble; the top bit of the spare nibble is shifted out, so it is not kept.
    for (genvar gi = 0; gi < NIBS; gi++) begin : g_adj
        if (gi < NIBS - 1) begin : g_full
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end else begin : g_top
            assign bcd_adj[4*gi +: 3] = 3'((bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4]);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;
`endif

    always_comb begin
        digits_fmt = bcd_q[4*DIGITS-1:0];
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) seen_nz = 1'b1;
            if (!seen_nz) digits_fmt[4*k +: 4] = 4'hF;
        end
`endif
        if (ovf_cap_q) digits_fmt = {DIGITS{4'hE}};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        ovf_cap_d = ovf_cap_q;
        digit_d   = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    shift_d   = VALUE;
                    bcd_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    busy_d    = 1'b1;
                    ovf_cap_d = (32'(VALUE) > LIMIT);
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q, 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                digit_d = digits_fmt;
                ovf_d   = ovf_cap_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cap_q <= 1'b0;
            digit_q   <= {DIGITS{4'hF}};
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ovf_cap_q <= ovf_cap_d;
            digit_q   <= digit_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign OVF       = ovf_q;
    assign DIGIT_BUS = digit_q;

endmodule

// File: tb/tb_pulse_bcd_digits.sv
// Self-checking bench for pulse_bcd_digits: directed cases plus random conversions against a decimal model.
module tb_pulse_bcd_digits;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;
    localparam int BW     = 4 * DIGITS;

    logic            CLOCK = 1'b0;
    logic            RESET_N;
    logic            START;
    logic [WIDTH-1:0] VALUE;
    logic            BUSY, DONE, OVF;
    logic [BW-1:0]   DIGIT_BUS;

    int n_cmp = 0;
    int n_err = 0;
    logic [BW-1:0] exp_bus;
    logic          exp_ovf;

    pulse_bcd_digits #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .VALUE(VALUE),
        .BUSY(BUSY), .DONE(DONE), .OVF(OVF), .DIGIT_BUS(DIGIT_BUS)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int limit_val();
        int p = 1;
        for (int i = 0; i < DIGITS; i++) p *= 10;
        return p - 1;
    endfunction

    // Decimal reference: digits by division, overflow shows 'e', optional leading-zero blanking.
    function automatic logic [BW-1:0] model(input int v);
        logic [BW-1:0] r;
        int p = 1;
        r = '0;
        if (v > limit_val()) return {DIGITS{4'hE}};
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && v < p) r[4*k +: 4] = 4'hF;
`endif
            p *= 10;
        end
        return r;
    endfunction

    // One conversion; glitch_at > 0 pulses a spurious START before edge t0+glitch_at.
    task automatic do_conv(input int v, input int glitch_at);
        logic [BW-1:0] prev_bus;
        logic          prev_ovf;
        prev_bus = exp_bus;
        prev_ovf = exp_ovf;
        START = 1'b1;
        VALUE = WIDTH'(v);
        tick();
        START = 1'b0;
        VALUE = WIDTH'($urandom);
        chk("busy_after_start", {31'd0, BUSY}, 32'd1);
        for (int c = 1; c <= WIDTH; c++) begin
            if (c == glitch_at) begin
                START = 1'b1;
                VALUE = WIDTH'($urandom);
            end else begin
                START = 1'b0;
            end
            tick();
            chk("conv_busy_done", {30'd0, BUSY, DONE}, 32'd2);
            chk("conv_hold_bus", 32'(DIGIT_BUS), 32'(prev_bus));
            chk("conv_hold_ovf", {31'd0, OVF}, {31'd0, prev_ovf});
        end
        START = 1'b0;
        tick();
        exp_bus = model(v);
        exp_ovf = (v > limit_val());
        chk("done_pulse", {31'd0, DONE}, 32'd1);
        chk("done_busy_low", {31'd0, BUSY}, 32'd0);
        chk("done_bus", 32'(DIGIT_BUS), 32'(exp_bus));
        chk("done_ovf", {31'd0, OVF}, {31'd0, exp_ovf});
        tick();
        chk("done_one_cycle", {31'd0, DONE}, 32'd0);
        chk("post_hold_bus", 32'(DIGIT_BUS), 32'(exp_bus));
        $display("conv value=%0d bus=%h ovf=%0b glitch=%0d", v, DIGIT_BUS, OVF, glitch_at);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        int va, vb, v;
        RESET_N = 1'b0;
        START   = 1'b0;
        VALUE   = '0;
        repeat (3) tick();
        exp_bus = {DIGITS{4'hF}};
        exp_ovf = 1'b0;
        chk("rst_bus", 32'(DIGIT_BUS), 32'hFFFF);
        chk("rst_flags", {29'd0, BUSY, DONE, OVF}, 32'd0);
        RESET_N = 1'b1;

        // Idle after reset: display dark, flags quiet.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_bus", 32'(DIGIT_BUS), 32'hFFFF);
            chk("idle_flags", {29'd0, BUSY, DONE, OVF}, 32'd0);
        end

        do_conv(1234, 0);
        do_conv(42, 0);
        do_conv(0, 0);
        do_conv(9999, 0);
        do_conv(10000, 0);
        do_conv(7, 0);
        do_conv(500, 5);
        do_conv(16383, 0);

        // Reset in the middle of a conversion aborts it.
        START = 1'b1;
        VALUE = WIDTH'(8888);
        tick();
        START = 1'b0;
        repeat (5) tick();
        RESET_N = 1'b0;
        tick();
        chk("abort_bus", 32'(DIGIT_BUS), 32'hFFFF);
        chk("abort_flags", {29'd0, BUSY, DONE, OVF}, 32'd0);
        RESET_N = 1'b1;
        exp_bus = {DIGITS{4'hF}};
        exp_ovf = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        $display("abort reset bus=%h busy=%0b", DIGIT_BUS, BUSY);
        do_conv(8888, 0);

        // START held high: conversions restart every WIDTH+2 cycles.
        va = 3071;
        vb = 58;
        START = 1'b1;
        VALUE = WIDTH'(va);
        tick();
        VALUE = WIDTH'(vb);
        first_done = -1;
        second_done = -1;
        done_cnt = 0;
        for (int i = 1; i <= 2 * WIDTH + 4; i++) begin
            if (i == 2 * WIDTH + 4) START = 1'b0;
            tick();
            if (DONE) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            if (i == WIDTH + 1) chk("b2b_first_bus", 32'(DIGIT_BUS), 32'(model(va)));
        end
        chk("b2b_first_at", 32'(first_done), 32'(WIDTH + 1));
        chk("b2b_second_at", 32'(second_done), 32'(2 * WIDTH + 3));
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        chk("b2b_second_bus", 32'(DIGIT_BUS), 32'(model(vb)));
        chk("b2b_idle", {31'd0, BUSY}, 32'd0);
        $display("b2b values=%0d,%0d dones at %0d,%0d", va, vb, first_done, second_done);
        exp_bus = model(vb);
        exp_ovf = 1'b0;

        // Random conversions, biased toward the overflow boundary.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(9990, 10010);
                1:       v = $urandom_range(0, 120);
                default: v = $urandom_range(0, (1 << WIDTH) - 1);
            endcase
            do_conv(v, ($urandom_range(0, 2) == 0) ? $urandom_range(1, WIDTH) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
